axi_lite_selftest_master: RTL and testbench

Synthesisable AXI4-Lite master that runs the register write/read-back self-test in hardware, generalised in register count, data width, address stride and ordering mode. On a start pulse it writes a generated pattern to C_NUM_REGS consecutive slave registers, reads each back, compares, and reports pass/fail, error count and the first mismatch. It sits on an interconnect master port in front of custom slave IP and serves bring-up and in-field health checks.

---
 rtl/axi_selftest_pkg.sv | 37 +++
 rtl/axi_lite_selftest_master_if.sv | 43 ++++
 rtl/axi_selftest_timeout.sv | 37 +++
 rtl/axi_lite_selftest_master.sv | 232 +++++++++++++++++++++++
 tb/tb_axi_lite_selftest_master.sv | 403 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/axi_selftest_pkg.sv
// rtl/axi_selftest_pkg.sv - shared types and helpers for the AXI4-Lite self-test master
// Contents: FSM state enum, AXI response codes, saturating error counter
// increment, and the test pattern generator.
package axi_selftest_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR,
    S_WB,
    S_RA,
    S_RD,
    S_NEXT,
    S_FIN
  } state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;

  // EXOKAY has no meaning on AXI4-Lite, so it is an error just like
  // SLVERR/DECERR (bit 1 set).
  function automatic logic resp_is_error(input logic [1:0] resp);
    return (resp == RESP_EXOKAY) || resp[1];
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Computed at 64 bits; the caller truncates to the data width, which
  // gives the modulo-2^DW wrap.
  function automatic logic [63:0] pattern(input logic [63:0] seed,
                                          input logic [63:0] step,
                                          input logic [7:0]  k);
    return seed + ({56'd0, k} * step);
  endfunction

endpackage

// File: rtl/axi_lite_selftest_master_if.sv
// rtl/axi_lite_selftest_master_if.sv - AXI4-Lite bus bundle with master/slave modports
// Signals: aw*, w*, b*, ar*, r* channels; the master drives addresses, data,
// VALIDs on AW/W/AR, and READYs on B/R.
interface axi_lite_selftest_master_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic [AW-1:0]   awaddr;
  logic [2:0]      awprot;
  logic            awvalid;
  logic            awready;
  logic [DW-1:0]   wdata;
  logic [DW/8-1:0] wstrb;
  logic            wvalid;
  logic            wready;
  logic [1:0]      bresp;
  logic            bvalid;
  logic            bready;
  logic [AW-1:0]   araddr;
  logic [2:0]      arprot;
  logic            arvalid;
  logic            arready;
  logic [DW-1:0]   rdata;
  logic [1:0]      rresp;
  logic            rvalid;
  logic            rready;

  modport master (
    output awaddr, awprot, awvalid, input awready,
    output wdata, wstrb, wvalid, input wready,
    input  bresp, bvalid, output bready,
    output araddr, arprot, arvalid, input arready,
    input  rdata, rresp, rvalid, output rready
  );

  modport slave (
    input  awaddr, awprot, awvalid, output awready,
    input  wdata, wstrb, wvalid, output wready,
    output bresp, bvalid, input bready,
    input  araddr, arprot, arvalid, output arready,
    output rdata, rresp, rvalid, input rready
  );
endinterface

// File: rtl/axi_selftest_timeout.sv
// rtl/axi_selftest_timeout.sv - loadable down-counter timing one channel wait
// Ports: clk, rst_n (async active-low), load_i (reload on state entry),
// expired_o (high for exactly one cycle, the C_CYCLES-th cycle after load).
module axi_selftest_timeout #(
  parameter int C_CYCLES = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load_i,
  output logic expired_o
);
  localparam int CW = $clog2(C_CYCLES + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Counts down to zero and parks there, so a wait that keeps going after
  // expiry never reports a second expiry.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = CW'(C_CYCLES);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Depends only on the register so the FSM may feed load_i from next-state.
  assign expired_o = (cnt_q == CW'(1));
endmodule

// File: rtl/axi_lite_selftest_master.sv
// rtl/axi_lite_selftest_master.sv - AXI4-Lite register write/read-back self-test master
// Ports: M_AXI_ACLK/M_AXI_ARESETN clock and async active-low reset; start/mode
// request a test; busy/done/pass/err_count/first_err_idx/first_err_data/timeout
// report it; m_axi is the AXI4-Lite master port.
module axi_lite_selftest_master
  import axi_selftest_pkg::*;
#(
  parameter int                          C_M_AXI_ADDR_WIDTH = 32,
  parameter int                          C_M_AXI_DATA_WIDTH = 32,
  parameter int                          C_NUM_REGS         = 4,
  parameter logic [C_M_AXI_ADDR_WIDTH-1:0] C_BASE_ADDR      = 32'h43C0_0000,
  parameter int                          C_ADDR_STRIDE      = 4,
  parameter logic [31:0]                 C_PATTERN_SEED     = 32'h0101_FFFF,
  parameter logic [31:0]                 C_PATTERN_STEP     = 32'h0001_0001,
  parameter int                          C_TIMEOUT_CYCLES   = 1024
) (
  input  logic                          M_AXI_ACLK,
  input  logic                          M_AXI_ARESETN,
  input  logic                          start,
  input  logic                          mode,
  output logic                          busy,
  output logic                          done,
  output logic                          pass,
  output logic [15:0]                   err_count,
  output logic [7:0]                    first_err_idx,
  output logic [C_M_AXI_DATA_WIDTH-1:0] first_err_data,
  output logic                          timeout,
  axi_lite_selftest_master_if.master    m_axi
);
  localparam int AW = C_M_AXI_ADDR_WIDTH;
  localparam int DW = C_M_AXI_DATA_WIDTH;
  localparam logic [7:0] LAST = 8'(C_NUM_REGS - 1);

  state_t          state_q, state_d;
  logic [7:0]      k_q, k_d;
  logic            mode_q, mode_d;
  logic            aw_done_q, aw_done_d;
  logic            w_done_q, w_done_d;
  logic            pass_q, pass_d;
  logic [15:0]     err_q, err_d;
  logic [7:0]      fidx_q, fidx_d;
  logic [DW-1:0]   fdata_q, fdata_d;
  logic            tmo_q, tmo_d;

  logic            awvalid, wvalid, bready, arvalid, rready;
  logic            aw_fin, w_fin;
  logic            err_ev;
  logic [DW-1:0]   err_rdata;
  logic [DW-1:0]   cur_pat;
  logic [AW-1:0]   cur_addr;
  logic            tmo_load, tmo_expired;

  assign cur_pat  = DW'(pattern(64'(C_PATTERN_SEED), 64'(C_PATTERN_STEP), k_q));
  assign cur_addr = C_BASE_ADDR + (AW'(k_q) * AW'(C_ADDR_STRIDE));

  // Every state entry restarts the wait budget; IDLE keeps it primed.
  assign tmo_load = (state_d != state_q) || (state_q == S_IDLE);

  axi_selftest_timeout #(.C_CYCLES(C_TIMEOUT_CYCLES)) u_timeout (
    .clk      (M_AXI_ACLK),
    .rst_n    (M_AXI_ARESETN),
    .load_i   (tmo_load),
    .expired_o(tmo_expired)
  );

  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    mode_d    = mode_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    pass_d    = pass_q;
    err_d     = err_q;
    fidx_d    = fidx_q;
    fdata_d   = fdata_q;
    tmo_d     = tmo_q;
    awvalid   = 1'b0;
    wvalid    = 1'b0;
    bready    = 1'b0;
    arvalid   = 1'b0;
    rready    = 1'b0;
    aw_fin    = 1'b0;
    w_fin     = 1'b0;
    err_ev    = 1'b0;
    err_rdata = '0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          err_d     = '0;
          fidx_d    = '0;
          fdata_d   = '0;
          tmo_d     = 1'b0;
          pass_d    = 1'b0;
          k_d       = '0;
          mode_d    = mode;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = S_WR;
        end
      end
      S_WR: begin
        // AW and W complete independently; each VALID drops after its own
        // handshake, the phase ends once both have been accepted.
        awvalid = !aw_done_q;
        wvalid  = !w_done_q;
        aw_fin  = aw_done_q || m_axi.awready;
        w_fin   = w_done_q || m_axi.wready;
        if (aw_fin && w_fin) begin
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = S_WB;
        end else begin
          aw_done_d = aw_fin;
          w_done_d  = w_fin;
          if (tmo_expired) begin
            err_ev = 1'b1;
            tmo_d  = 1'b1;
          end
        end
      end
      S_WB: begin
        bready = 1'b1;
        if (m_axi.bvalid) begin
          err_ev = resp_is_error(m_axi.bresp);
          if (!mode_q) begin
            state_d = S_RA;
          end else if (k_q == LAST) begin
            k_d     = '0;
            state_d = S_RA;
          end else begin
            k_d     = k_q + 8'd1;
            state_d = S_WR;
          end
        end else if (tmo_expired) begin
          err_ev  = 1'b1;
          tmo_d   = 1'b1;
          state_d = S_NEXT;
        end
      end
      S_RA: begin
        arvalid = 1'b1;
        if (m_axi.arready) begin
          state_d = S_RD;
        end else if (tmo_expired) begin
          err_ev = 1'b1;
          tmo_d  = 1'b1;
        end
      end
      S_RD: begin
        rready = 1'b1;
        if (m_axi.rvalid) begin
          err_ev    = (m_axi.rdata != cur_pat) || resp_is_error(m_axi.rresp);
          err_rdata = m_axi.rdata;
          state_d   = S_NEXT;
        end else if (tmo_expired) begin
          err_ev  = 1'b1;
          tmo_d   = 1'b1;
          state_d = S_NEXT;
        end
      end
      S_NEXT: begin
        if (k_q == LAST) begin
          state_d = S_FIN;
        end else begin
          k_d     = k_q + 8'd1;
          state_d = mode_q ? S_RA : S_WR;
        end
      end
      S_FIN: begin
        pass_d  = (err_q == 16'd0);
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // A saturated counter never returns to zero, so zero means "no error yet".
    if (err_ev) begin
      if (err_q == 16'd0) begin
        fidx_d  = k_q;
        fdata_d = err_rdata;
      end
      err_d = sat_inc16(err_q);
    end
  end

  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN) begin
      state_q   <= S_IDLE;
      k_q       <= '0;
      mode_q    <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      pass_q    <= 1'b0;
      err_q     <= '0;
      fidx_q    <= '0;
      fdata_q   <= '0;
      tmo_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      mode_q    <= mode_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      pass_q    <= pass_d;
      err_q     <= err_d;
      fidx_q    <= fidx_d;
      fdata_q   <= fdata_d;
      tmo_q     <= tmo_d;
    end
  end

  assign busy           = (state_q != S_IDLE) && (state_q != S_FIN);
  assign done           = (state_q == S_FIN);
  assign pass           = pass_q;
  assign err_count      = err_q;
  assign first_err_idx  = fidx_q;
  assign first_err_data = fdata_q;
  assign timeout        = tmo_q;

  assign m_axi.awaddr  = cur_addr;
  assign m_axi.awprot  = 3'b000;
  assign m_axi.awvalid = awvalid;
  assign m_axi.wdata   = cur_pat;
  assign m_axi.wstrb   = '1;
  assign m_axi.wvalid  = wvalid;
  assign m_axi.bready  = bready;
  assign m_axi.araddr  = cur_addr;
  assign m_axi.arprot  = 3'b000;
  assign m_axi.arvalid = arvalid;
  assign m_axi.rready  = rready;
endmodule

// File: tb/tb_axi_lite_selftest_master.sv
// tb/tb_axi_lite_selftest_master.sv - self-checking bench for axi_lite_selftest_master
module tb_axi_lite_selftest_master;
  localparam logic [31:0] BASE = 32'h43C0_0000;
  localparam logic [31:0] SEED = 32'h0101_FFFF;
  localparam logic [31:0] STEP = 32'h0001_0001;
  localparam int          N    = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        mode = 1'b0;
  logic        busy, done, pass, timeout;
  logic [15:0] err_count;
  logic [7:0]  first_err_idx;
  logic [31:0] first_err_data;

  int n_checks = 0;
  int n_errors = 0;

  axi_lite_selftest_master_if #(.AW(32), .DW(32)) bus ();

  axi_lite_selftest_master #(.C_TIMEOUT_CYCLES(16)) dut (
    .M_AXI_ACLK    (clk),
    .M_AXI_ARESETN (rst_n),
    .start         (start),
    .mode          (mode),
    .busy          (busy),
    .done          (done),
    .pass          (pass),
    .err_count     (err_count),
    .first_err_idx (first_err_idx),
    .first_err_data(first_err_data),
    .timeout       (timeout),
    .m_axi         (bus)
  );

  always #5 clk = ~clk;

  // Slave behaviour knobs (-1 disables an injected fault).
  int aw_delay, corrupt_idx, bresp_err_idx, rresp_err_idx, hang_idx;

  logic [71:0] exp_q[$];
  logic [71:0] obs_q[$];

  logic [31:0] mem [0:7];
  int          aw_cnt;
  logic        a_got, w_got, s_bvalid, s_rvalid;
  logic [31:0] a_addr, w_data, s_rdata;
  logic [1:0]  s_bresp, s_rresp;
  logic        aw_hs, w_hs, ar_hs;
  logic [31:0] s_wa, s_wd, s_widx, s_ridx;

  assign bus.awready = bus.awvalid && (aw_cnt >= aw_delay);
  assign bus.wready  = bus.wvalid;
  assign bus.arready = bus.arvalid;
  assign bus.bvalid  = s_bvalid;
  assign bus.bresp   = s_bresp;
  assign bus.rvalid  = s_rvalid;
  assign bus.rresp   = s_rresp;
  assign bus.rdata   = s_rdata;

  assign aw_hs  = bus.awvalid && bus.awready;
  assign w_hs   = bus.wvalid && bus.wready;
  assign ar_hs  = bus.arvalid && bus.arready;
  assign s_wa   = aw_hs ? bus.awaddr : a_addr;
  assign s_wd   = w_hs ? bus.wdata : w_data;
  assign s_widx = (s_wa - BASE) >> 2;
  assign s_ridx = (bus.araddr - BASE) >> 2;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aw_cnt   <= 0;
      a_got    <= 1'b0;
      w_got    <= 1'b0;
      a_addr   <= '0;
      w_data   <= '0;
      s_bvalid <= 1'b0;
      s_bresp  <= 2'b00;
      s_rvalid <= 1'b0;
      s_rresp  <= 2'b00;
      s_rdata  <= '0;
      for (int i = 0; i < 8; i++) mem[i] <= '0;
    end else begin
      if (bus.awvalid && !bus.awready) aw_cnt <= aw_cnt + 1;
      if (aw_hs) begin
        aw_cnt <= 0;
        a_got  <= 1'b1;
        a_addr <= bus.awaddr;
      end
      if (w_hs) begin
        w_got  <= 1'b1;
        w_data <= bus.wdata;
      end
      if ((a_got || aw_hs) && (w_got || w_hs) && !s_bvalid) begin
        mem[s_widx[2:0]] <= s_wd;
        obs_q.push_back({1'b1, bus.awprot, bus.wstrb, s_wa, s_wd});
        s_bvalid <= 1'b1;
        s_bresp  <= (int'(s_widx) == bresp_err_idx) ? 2'b10 : 2'b00;
        a_got    <= 1'b0;
        w_got    <= 1'b0;
      end
      if (s_bvalid && bus.bready) s_bvalid <= 1'b0;
      if (ar_hs) begin
        obs_q.push_back({1'b0, bus.arprot, 4'h0, bus.araddr, 32'h0});
        if (int'(s_ridx) != hang_idx) s_rvalid <= 1'b1;
        s_rdata <= (int'(s_ridx) == corrupt_idx) ? 32'hDEAD0011 : mem[s_ridx[2:0]];
        s_rresp <= (int'(s_ridx) == rresp_err_idx) ? 2'b10 : 2'b00;
      end
      if (s_rvalid && bus.rready) s_rvalid <= 1'b0;
    end
  end

  // Scoreboard: each bus transaction the slave sees is matched in order
  // against the sequence queued when the test was started.
  initial begin : scoreboard
    logic [71:0] o, e;
    forever begin
      @(negedge clk);
      while (obs_q.size() != 0) begin
        o = obs_q.pop_front();
        n_checks++;
        if (exp_q.size() == 0) begin
          n_errors++;
          $display("FAIL sb_unexpected: got %h expected no transaction", o);
        end else begin
          e = exp_q.pop_front();
          if (o !== e) begin
            n_errors++;
            $display("FAIL sb_txn: got %h expected %h", o, e);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic cfg_default();
    aw_delay      = 0;
    corrupt_idx   = -1;
    bresp_err_idx = -1;
    rresp_err_idx = -1;
    hang_idx      = -1;
  endtask

  function automatic logic [71:0] exp_wr(input int k);
    return {1'b1, 3'b000, 4'hF, BASE + 32'(k) * 32'd4, SEED + 32'(k) * STEP};
  endfunction

  function automatic logic [71:0] exp_rd(input int k);
    return {1'b0, 3'b000, 4'h0, BASE + 32'(k) * 32'd4, 32'h0};
  endfunction

  task automatic push_expected(input logic m);
    if (!m) begin
      for (int k = 0; k < N; k++) begin
        exp_q.push_back(exp_wr(k));
        exp_q.push_back(exp_rd(k));
      end
    end else begin
      for (int k = 0; k < N; k++) exp_q.push_back(exp_wr(k));
      for (int k = 0; k < N; k++) exp_q.push_back(exp_rd(k));
    end
  endtask

  task automatic pulse_start(input logic m);
    @(negedge clk);
    mode  = m;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Returns the number of cycles from the one after start up to the done cycle.
  task automatic wait_done(output int cyc);
    cyc = 1;
    while (done !== 1'b1 && cyc < 400) begin
      @(negedge clk);
      cyc++;
    end
    if (done !== 1'b1) begin
      n_checks++;
      n_errors++;
      $display("FAIL wait_done: done=%b after %0d cycles, expected 1", done, cyc);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_checks++;
    if ({busy, done, pass, timeout, err_count, first_err_idx, first_err_data} !== '0) begin
      n_errors++;
      $display("FAIL reset_status: got %b%b%b%b %h %h %h expected all zero",
               busy, done, pass, timeout, err_count, first_err_idx, first_err_data);
    end
    n_checks++;
    if ({bus.awvalid, bus.wvalid, bus.bready, bus.arvalid, bus.rready} !== 5'b0) begin
      n_errors++;
      $display("FAIL reset_handshake: got %b expected 00000",
               {bus.awvalid, bus.wvalid, bus.bready, bus.arvalid, bus.rready});
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || bus.awvalid !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_idle: got busy=%b awvalid=%b expected 0 0", busy, bus.awvalid);
    end
  endtask

  task automatic test_interleaved();
    int cyc;
    cfg_default();
    push_expected(1'b0);
    pulse_start(1'b0);
    wait_done(cyc);
    n_checks++;
    if (cyc + 1 != 22) begin
      n_errors++;
      $display("FAIL t1_latency: got %0d cycles expected 22", cyc + 1);
    end
    n_checks++;
    if (pass !== 1'b1 || err_count !== 16'd0 || timeout !== 1'b0) begin
      n_errors++;
      $display("FAIL t1_result: got pass=%b err=%0d tmo=%b expected 1 0 0", pass, err_count, timeout);
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL t1_txn_left: got %0d pending expected 0", exp_q.size());
    end
  endtask

  task automatic test_write_then_read();
    int cyc;
    cfg_default();
    aw_delay = 3;
    push_expected(1'b1);
    pulse_start(1'b1);
    wait_done(cyc);
    n_checks++;
    if (pass !== 1'b1 || err_count !== 16'd0) begin
      n_errors++;
      $display("FAIL t2_result: got pass=%b err=%0d expected 1 0", pass, err_count);
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL t2_txn_left: got %0d pending expected 0", exp_q.size());
    end
  endtask

  task automatic test_corrupt();
    int cyc;
    cfg_default();
    corrupt_idx = 2;
    push_expected(1'b0);
    pulse_start(1'b0);
    wait_done(cyc);
    n_checks++;
    if (pass !== 1'b0 || err_count !== 16'd1) begin
      n_errors++;
      $display("FAIL t3_result: got pass=%b err=%0d expected 0 1", pass, err_count);
    end
    n_checks++;
    if (first_err_idx !== 8'd2 || first_err_data !== 32'hDEAD0011) begin
      n_errors++;
      $display("FAIL t3_first_err: got idx=%0d data=%h expected 2 dead0011", first_err_idx, first_err_data);
    end
  endtask

  task automatic test_resp_err();
    int cyc;
    cfg_default();
    bresp_err_idx = 1;
    rresp_err_idx = 3;
    push_expected(1'b0);
    pulse_start(1'b0);
    wait_done(cyc);
    n_checks++;
    if (err_count !== 16'd2 || first_err_idx !== 8'd1 || pass !== 1'b0) begin
      n_errors++;
      $display("FAIL t4_result: got err=%0d idx=%0d pass=%b expected 2 1 0", err_count, first_err_idx, pass);
    end
  endtask

  task automatic test_timeout();
    int cyc;
    int rd_cycles;
    cfg_default();
    hang_idx = 0;
    push_expected(1'b0);
    pulse_start(1'b0);
    rd_cycles = 0;
    cyc = 0;
    while (timeout !== 1'b1 && cyc < 200) begin
      if (bus.rready === 1'b1) rd_cycles++;
      @(negedge clk);
      cyc++;
    end
    n_checks++;
    if (rd_cycles != 16 || timeout !== 1'b1) begin
      n_errors++;
      $display("FAIL t5_timeout_at: got %0d RD cycles tmo=%b expected 16 1", rd_cycles, timeout);
    end
    wait_done(cyc);
    n_checks++;
    if (timeout !== 1'b1 || err_count < 16'd1 || first_err_idx !== 8'd0 || pass !== 1'b0) begin
      n_errors++;
      $display("FAIL t5_result: got tmo=%b err=%0d idx=%0d pass=%b expected 1 >=1 0 0",
               timeout, err_count, first_err_idx, pass);
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL t5_txn_left: got %0d pending expected 0", exp_q.size());
    end
  endtask

  task automatic test_start_while_busy();
    int cyc;
    cfg_default();
    push_expected(1'b0);
    pulse_start(1'b0);
    repeat (3) @(negedge clk);
    n_checks++;
    if (busy !== 1'b1) begin
      n_errors++;
      $display("FAIL t6_busy: got %b expected 1", busy);
    end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(cyc);
    repeat (5) @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || pass !== 1'b1 || exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL t6_no_restart: got busy=%b pass=%b pending=%0d expected 0 1 0", busy, pass, exp_q.size());
    end
  endtask

  task automatic test_reset_midway();
    int cyc;
    cfg_default();
    corrupt_idx = 0;
    push_expected(1'b0);
    pulse_start(1'b0);
    cyc = 0;
    while (!(bus.awvalid === 1'b1 && bus.awaddr === BASE + 32'd4) && cyc < 60) begin
      @(negedge clk);
      cyc++;
    end
    n_checks++;
    if (cyc >= 60 || err_count !== 16'd1 || first_err_data !== 32'hDEAD0011) begin
      n_errors++;
      $display("FAIL t6_pre_reset: got cyc=%0d err=%0d data=%h expected <60 1 dead0011",
               cyc, err_count, first_err_data);
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({busy, done, pass, timeout, err_count, first_err_idx, first_err_data,
         bus.awvalid, bus.wvalid, bus.bready, bus.arvalid, bus.rready} !== '0) begin
      n_errors++;
      $display("FAIL t6_async_reset: got busy=%b err=%0d data=%h awvalid=%b wvalid=%b expected all zero",
               busy, err_count, first_err_data, bus.awvalid, bus.wvalid);
    end
    repeat (2) @(negedge clk);
    exp_q.delete();
    obs_q.delete();
    rst_n = 1'b1;
    @(negedge clk);
    cfg_default();
    push_expected(1'b1);
    pulse_start(1'b1);
    wait_done(cyc);
    n_checks++;
    if (pass !== 1'b1 || err_count !== 16'd0 || exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL t6_restart: got pass=%b err=%0d pending=%0d expected 1 0 0", pass, err_count, exp_q.size());
    end
  endtask

  initial begin
    cfg_default();
    test_reset();
    test_interleaved();
    test_write_then_read();
    test_corrupt();
    test_resp_err();
    test_timeout();
    test_start_while_busy();
    test_reset_midway();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
